cube_layer_driver: RTL and testbench
====================================

// Module: cube_layer_driver
// PURPOSE
//  Display-side consumer of the 512-bit Cells frame (bit index = x + 8*y + 64*z) of the 8x8x8 LED cube.
//  Captures frames into a double buffer and multiplexes the cube one y-layer at a time.
//  Serialises each layer's 64 column bits into external shift/storage registers and drives one-hot
//  layer enables.
//  Sits between the simulator core and the cube's board pins.
// PARAMETERS
//  CLK_DIV       4     Clk cycles per SerClk half-period (>=1)
//  BLANK_CYCLES  16    Clk cycles all layers are off before each Latch (>=1)
//  LAYER_HOLD    1024  Clk cycles a layer is lit after Latch (>=1)
// PORTS
//  Clk         in   1    system clock, all logic on posedge
//  Reset       in   1    asynchronous, active-low reset
//  Cells       in   512  frame from the simulator
//  FrameStrobe in   1    1 = capture Cells into the pending buffer this cycle
//  FrameTaken  out  1    1-cycle pulse: pending frame copied to the active buffer
//  SerData     out  1    column data to the shift register
//  SerClk      out  1    shift clock; the external register samples on the rising edge
//  Latch       out  1    storage-register load, 1 Clk cycle wide
//  LayerEn     out  8    one-hot layer enable, bit n = layer y=n; all 0 = blank
// BEHAVIOUR
//  Reset (async, Reset=0):
//   - SerData, SerClk, Latch, FrameTaken = 0; LayerEn = 8'h00.
//   - Both buffers = 0; pending flag = 0; layer = 0; state = LOAD.
//   - Reset asserted mid-operation aborts immediately, including a partial shift.
//  Frame capture:
//   - FrameStrobe=1 writes pend_buf <= Cells and sets pend_flag in every state.
//   - A later strobe overwrites an unconsumed frame; the last strobe wins.
//  FSM:
//   - LOAD (1 cycle, entered only at layer 0):
//     - if pend_flag: act_buf <= pend_buf, clear pend_flag, FrameTaken=1.
//     - If FrameStrobe and the copy occur in the same cycle: the copy uses the old pend_buf;
//       the new frame is stored and pend_flag stays 1.
//     - Then go to SHIFT.
//   - SHIFT: 64 bits, sent as r = 63 down to 0, where r = x + 8*z. Each bit is
//     act_buf[x + 8*layer + 64*z].
//     - Per bit, SerData is set on entry with SerClk=0 for CLK_DIV cycles, then SerClk=1 for
//       CLK_DIV cycles.
//     - Total: 128*CLK_DIV cycles. Then go to BLANK.
//   - BLANK: LayerEn=0, SerClk=0 for BLANK_CYCLES cycles. Then go to LATCH.
//   - LATCH: Latch=1 for exactly 1 cycle, LayerEn=0. Then go to HOLD.
//   - HOLD: LayerEn = 1<<layer for LAYER_HOLD cycles. Then layer <= layer+1.
//     - Layer wraps 7 -> 0; on wrap go to LOAD, else go to SHIFT.
//  LayerEn is nonzero only in HOLD, so at most one layer is lit at a time.
//  Per-layer period: 128*CLK_DIV + BLANK_CYCLES + 1 + LAYER_HOLD cycles; add 1 for LOAD at layer 0.
//  act_buf changes only in LOAD, so a displayed frame is never torn across layers.
//  Counters are sized by $clog2 of their maximum and wrap only as stated above.
//  SerData holds its last value outside SHIFT.
// TESTING
//  (defaults unless noted: CLK_DIV=1, BLANK_CYCLES=2, LAYER_HOLD=4)
//  1. Reset=0 mid-SHIFT -> next cycle all outputs 0 and LayerEn=0; after release FSM restarts at
//     LOAD, layer 0, FrameTaken=0.
//  2. Cells = all ones on the y=2 plane, strobe once -> FrameTaken pulses once. The bit stream is
//     64 ones for layer 2 and all zeros for other layers. LayerEn sequence: 01,02,04,...,80, then 01.
//  3. Cells bit0 only (x=0,y=0,z=0) -> in layer 0, SerData=1 on the 64th (last) SerClk rise only.
//     Period from LOAD to layer-1 SHIFT = 1+128+2+1+4 = 136 cycles.
//  4. FrameStrobe with A then B during layer 3 -> at the next LOAD, act_buf=B, one FrameTaken pulse.
//     A is never displayed.
//  5. FrameStrobe in the same cycle as LOAD copy (pend_flag=1) -> the old frame is displayed;
//     the new frame is taken at the following LOAD.
//  6. Every cycle check: $countones(LayerEn) <= 1; Latch=1 only when LayerEn=0; SerClk=0 outside SHIFT.

Source files
------------

// File: rtl/cube_layer_driver_if.sv
// cube_layer_driver_if: frame input and cube board pins of cube_layer_driver
interface cube_layer_driver_if;
    logic [511:0] Cells;
    logic         FrameStrobe;
    logic         FrameTaken;
    logic         SerData;
    logic         SerClk;
    logic         Latch;
    logic [7:0]   LayerEn;

    modport master (
        output Cells, FrameStrobe,
        input  FrameTaken, SerData, SerClk, Latch, LayerEn
    );

    modport slave (
        input  Cells, FrameStrobe,
        output FrameTaken, SerData, SerClk, Latch, LayerEn
    );
endinterface

// File: rtl/cube_layer_driver.sv
// cube_layer_driver: double-buffers 512-bit cube frames and scans them out one y-layer at a time
// through an external shift/storage register pair with one-hot layer enables.
module cube_layer_driver #(
    parameter int CLK_DIV      = 4,
    parameter int BLANK_CYCLES = 16,
    parameter int LAYER_HOLD   = 1024
) (
    input logic               Clk,
    input logic               Reset,
    cube_layer_driver_if.slave io
);
    localparam logic [2:0] LOAD  = 3'd0;
    localparam logic [2:0] SHIFT = 3'd1;
    localparam logic [2:0] BLANK = 3'd2;
    localparam logic [2:0] LATCH = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;

    localparam int TMAX_DB = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int TMAX    = (TMAX_DB > LAYER_HOLD) ? TMAX_DB : LAYER_HOLD;
    localparam int TW      = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] DIV_LAST   = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(LAYER_HOLD - 1);

    logic [2:0]    state;
    logic [511:0]  pend_buf;
    logic [511:0]  act_buf;
    logic          pend_flag;
    logic [2:0]    layer;
    logic [5:0]    bit_idx;
    logic          phase;
    logic [TW-1:0] timer;
    logic          last_data;
    logic          cur_bit;
    logic          take;
    logic          tdone;

    assign take = (state == LOAD) && pend_flag;

    // Shift order r = x + 8*z maps onto the frame index {z, y, x}
    assign cur_bit = act_buf[{bit_idx[5:3], layer, bit_idx[2:0]}];

    always_comb begin
        tdone = (state == SHIFT) ? (timer == DIV_LAST) :
                (state == BLANK) ? (timer == BLANK_LAST) :
                (state == HOLD)  ? (timer == HOLD_LAST) : 1'b0;
    end

    assign io.FrameTaken = take;
    assign io.SerData    = (state == SHIFT) ? cur_bit : last_data;
    assign io.SerClk     = (state == SHIFT) && phase;
    assign io.Latch      = (state == LATCH);
    assign io.LayerEn    = (state == HOLD) ? (8'd1 << layer) : 8'h00;

    // A strobe coinciding with the copy keeps the new frame pending
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pend_buf  <= '0;
            act_buf   <= '0;
            pend_flag <= 1'b0;
        end else begin
            if (io.FrameStrobe) pend_buf <= io.Cells;
            if (take) act_buf <= pend_buf;
            pend_flag <= io.FrameStrobe || (pend_flag && !take);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= LOAD;
            layer     <= 3'd0;
            bit_idx   <= 6'd63;
            phase     <= 1'b0;
            timer     <= '0;
            last_data <= 1'b0;
        end else begin
            if (state == SHIFT) last_data <= cur_bit;
            case (state)
                LOAD: begin
                    state   <= SHIFT;
                    bit_idx <= 6'd63;
                    phase   <= 1'b0;
                end
                SHIFT: begin
                    timer <= tdone ? '0 : timer + 1'b1;
                    if (tdone) begin
                        phase <= !phase;
                        if (phase && bit_idx == 6'd0) state <= BLANK;
                        else if (phase) bit_idx <= bit_idx - 1'b1;
                    end
                end
                BLANK: begin
                    timer <= tdone ? '0 : timer + 1'b1;
                    if (tdone) state <= LATCH;
                end
                LATCH: state <= HOLD;
                HOLD: begin
                    timer <= tdone ? '0 : timer + 1'b1;
                    if (tdone) begin
                        layer   <= layer + 1'b1;
                        state   <= (layer == 3'd7) ? LOAD : SHIFT;
                        bit_idx <= 6'd63;
                        phase   <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_cube_layer_driver.sv
// tb_cube_layer_driver: directed frame vectors and multiplexing corner cases for cube_layer_driver
module tb_cube_layer_driver;
    typedef struct {
        logic [63:0] s;
        logic [7:0]  en;
        int          nb;
        int          cyc;
    } rec_t;

    typedef struct {
        logic [511:0] cells;
        int           layer;
        logic [63:0]  stream;
    } vec_t;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ft_cnt = 0;
    int ft_cyc = 0;
    rec_t q[$];

    cube_layer_driver_if d();

    cube_layer_driver #(.CLK_DIV(1), .BLANK_CYCLES(2), .LAYER_HOLD(4)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .io(d)
    );

    always #5 Clk = ~Clk;

    // Pin-level monitor: rebuilds each layer's shifted word and timestamps its HOLD start
    logic [63:0] sh = '0;
    int nb = 0;
    logic prev_clk = 1'b0;
    logic [7:0] prev_en = 8'h00;
    always @(negedge Clk) begin
        cyc++;
        checks += 3;
        if ($countones(d.LayerEn) > 1) begin
            errors++;
            $display("FAIL inv_onehot LayerEn=%h", d.LayerEn);
        end
        if (d.Latch && d.LayerEn != 8'h00) begin
            errors++;
            $display("FAIL inv_latch_blank LayerEn=%h with Latch=1, want 00", d.LayerEn);
        end
        if (d.SerClk && (d.LayerEn != 8'h00 || d.Latch)) begin
            errors++;
            $display("FAIL inv_serclk SerClk=1 with LayerEn=%h Latch=%b", d.LayerEn, d.Latch);
        end
        if (!Reset) begin
            sh = '0;
            nb = 0;
            prev_clk = 1'b0;
            prev_en = 8'h00;
        end else begin
            if (d.FrameTaken) begin
                ft_cnt++;
                ft_cyc = cyc;
            end
            if (d.SerClk && !prev_clk) begin
                sh = {sh[62:0], d.SerData};
                nb++;
            end
            if (d.LayerEn != 8'h00 && prev_en == 8'h00) begin
                q.push_back('{sh, d.LayerEn, nb, cyc});
                sh = '0;
                nb = 0;
            end
            prev_clk = d.SerClk;
            prev_en = d.LayerEn;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge Clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [511:0] c);
        d.Cells = c;
        d.FrameStrobe = 1'b1;
        tick();
        d.FrameStrobe = 1'b0;
    endtask

    task automatic wait_ft(input int base);
        int t = 0;
        while (ft_cnt == base && t < 3000) begin
            tick();
            t++;
        end
        chk("frame_taken_wait", 64'(ft_cnt > base), 64'd1);
    endtask

    task automatic wait_en(input logic [7:0] en);
        int t = 0;
        while (d.LayerEn !== en && t < 3000) begin
            tick();
            t++;
        end
        chk($sformatf("wait_layer_en_%h", en), 64'(d.LayerEn), 64'(en));
    endtask

    task automatic get_rec(output rec_t r);
        int t = 0;
        while (q.size() == 0 && t < 3000) begin
            tick();
            t++;
        end
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL record_timeout got no layer want one");
            r = '{64'd0, 8'd0, 0, 0};
        end else begin
            r = q.pop_front();
        end
    endtask

    task automatic check_frame(input string tag, input int layer, input logic [63:0] stream,
                               input int ft_base, input int prev7, output int last7);
        rec_t r;
        int c0 = 0;
        logic [7:0] e;
        for (int l = 0; l < 8; l++) begin
            get_rec(r);
            e = 8'd1 << l;
            chk($sformatf("%s_en_l%0d", tag, l), 64'(r.en), 64'(e));
            chk($sformatf("%s_bits_l%0d", tag, l), 64'(r.nb), 64'd64);
            chk($sformatf("%s_stream_l%0d", tag, l), r.s, (l == layer) ? stream : 64'd0);
            if (l == 0) begin
                chk($sformatf("%s_load_to_hold0", tag), 64'(r.cyc - ft_cyc), 64'd132);
                if (prev7 != 0) chk($sformatf("%s_hold7_to_hold0", tag), 64'(r.cyc - prev7), 64'd136);
                c0 = r.cyc;
            end
            if (l == 1) chk($sformatf("%s_hold0_to_hold1", tag), 64'(r.cyc - c0), 64'd135);
            last7 = r.cyc;
        end
        chk($sformatf("%s_taken_once", tag), 64'(ft_cnt - ft_base), 64'd1);
    endtask

    initial begin
        vec_t v[5];
        rec_t r;
        int base;
        int c7;
        logic [511:0] ones;
        logic [511:0] plane2;
        ones = '1;
        plane2 = '0;
        for (int z = 0; z < 8; z++)
            for (int x = 0; x < 8; x++)
                plane2[x + 16 + 64 * z] = 1'b1;
        v[0] = '{plane2, 2, 64'hFFFF_FFFF_FFFF_FFFF};
        v[1] = '{512'd1, 0, 64'h0000_0000_0000_0001};
        v[2] = '{512'd1 << 495, 5, 64'h8000_0000_0000_0000};
        v[3] = '{512'd1 << 99, 4, 64'h0000_0000_0000_0800};
        v[4] = '{512'd1 << 189, 7, 64'h0000_0000_0020_0000};

        d.Cells = '0;
        d.FrameStrobe = 1'b0;
        Reset = 1'b0;
        tick(2);
        chk("rst_serdata", 64'(d.SerData), 64'd0);
        chk("rst_serclk", 64'(d.SerClk), 64'd0);
        chk("rst_latch", 64'(d.Latch), 64'd0);
        chk("rst_frametaken", 64'(d.FrameTaken), 64'd0);
        chk("rst_layeren", 64'(d.LayerEn), 64'd0);
        Reset = 1'b1;
        tick();
        strobe(ones);
        for (int l = 0; l < 8; l++) begin
            get_rec(r);
            chk($sformatf("f0_en_l%0d", l), 64'(r.en), 64'(8'd1 << l));
            chk($sformatf("f0_stream_l%0d", l), r.s, 64'd0);
        end

        // Reset in the middle of an all-ones layer-0 shift with another frame pending
        base = ft_cnt;
        wait_ft(base);
        strobe(plane2);
        tick(39);
        chk("shift_data_ones", 64'(d.SerData), 64'd1);
        Reset = 1'b0;
        tick();
        chk("midrst_serdata", 64'(d.SerData), 64'd0);
        chk("midrst_serclk", 64'(d.SerClk), 64'd0);
        chk("midrst_latch", 64'(d.Latch), 64'd0);
        chk("midrst_frametaken", 64'(d.FrameTaken), 64'd0);
        chk("midrst_layeren", 64'(d.LayerEn), 64'd0);
        tick(2);
        Reset = 1'b1;
        q.delete();
        base = ft_cnt;
        get_rec(r);
        chk("restart_en", 64'(r.en), 64'h01);
        chk("restart_stream", r.s, 64'd0);
        chk("restart_bits", 64'(r.nb), 64'd64);
        chk("restart_no_take", 64'(ft_cnt - base), 64'd0);

        for (int i = 0; i < 5; i++) begin
            base = ft_cnt;
            strobe(v[i].cells);
            wait_ft(base);
            q.delete();
            check_frame($sformatf("vec%0d", i), v[i].layer, v[i].stream, base, 0, c7);
        end

        // Two strobes during layer 3: only the second is ever displayed
        wait_en(8'h08);
        base = ft_cnt;
        strobe(512'd1);
        strobe(512'd1 << 189);
        wait_ft(base);
        q.delete();
        check_frame("lastwins", 7, 64'h0000_0000_0020_0000, base, 0, c7);

        // Strobe landing on the LOAD copy cycle
        wait_en(8'h01);
        base = ft_cnt;
        strobe(plane2);
        wait_en(8'h80);
        tick(4);
        chk("coinc_load_take", 64'(d.FrameTaken), 64'd1);
        strobe(512'd1 << 99);
        q.delete();
        check_frame("coinc_old", 2, 64'hFFFF_FFFF_FFFF_FFFF, base, 0, c7);
        base = ft_cnt;
        wait_ft(base);
        q.delete();
        check_frame("coinc_new", 4, 64'h0000_0000_0000_0800, base, c7, c7);
        tick(10);
        chk("coinc_no_retake", 64'(ft_cnt - base), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        errors++;
        $display("FAIL watchdog got no finish want finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
